conv_output_stage: RTL and testbench

- Sits directly downstream of the 3x3 convolution/max-pool datapath and consumes its 20-bit signed result stream.
- Discards pipeline warm-up samples and, for max-pool, decimates 2x2 outputs.
- Requantises the result to signed 8-bit, rounding and saturating, then buffers it in a small FIFO.
- Presents the buffered result to the feature-map writer over a valid/ready interface, together with a linear output index.

---
 rtl/conv_output_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_conv_output_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_output_stage.sv
// Output stage of the 3x3 conv / 2x2 max-pool datapath: drops warm-up samples,
// decimates pooled outputs, requantises to int8 and buffers results for the writer.
module conv_output_stage #(
   parameter int IMAGE_WIDTH  = 128,
   parameter int IMAGE_HEIGHT = 128,
   parameter int ACC_WIDTH    = 20,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [7:0]           width,
   input  logic [7:0]           height,
   input  logic [1:0]           operation,
   input  logic [3:0]           shift,
   input  logic [ACC_WIDTH-1:0] acc_in,
   input  logic                 acc_valid,
   output logic [7:0]           pixel_out,
   output logic [15:0]          out_addr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow
);

   localparam int COL_W  = $clog2(IMAGE_WIDTH + 1);
   localparam int ROW_W  = $clog2(IMAGE_HEIGHT + 1);
   localparam int SKIP_W = COL_W + 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(127);
   localparam logic signed [ACC_WIDTH:0] SAT_MIN = -(ACC_WIDTH+1)'(128);
   localparam logic signed [ACC_WIDTH:0] RND_ONE = (ACC_WIDTH+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SKIP  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [7:0]        width_q, height_q;
   logic [1:0]        op_q;
   logic [3:0]        shift_q;
   logic [SKIP_W-1:0] skip_q;
   logic [COL_W-1:0]  col_q;
   logic [ROW_W-1:0]  row_q;
   logic [15:0]       idx_q;
   logic [PTR_W-1:0]  wr_q, rd_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [7:0]        pix_mem_q  [FIFO_DEPTH];
   logic [15:0]       addr_mem_q [FIFO_DEPTH];
   logic              busy_q, busy_d, done_q, done_d, ovf_q;

   logic                        start_s, sample_s, last_s, skip_done_s;
   logic                        keep_s, pop_s, push_s, full_s;
   logic signed [ACC_WIDTH:0]   acc_ext_s, round_s, sum_s, scaled_s;
   logic [7:0]                  y_s;

   function automatic logic [7:0] sat8(input logic signed [ACC_WIDTH:0] v);
      logic [7:0] r;
      if (v > SAT_MAX) begin
         r = 8'h7f;
      end else if (v < SAT_MIN) begin
         r = 8'h80;
      end else begin
         r = v[7:0];
      end
      return r;
   endfunction

   // Requantise: round-half-up arithmetic shift for conv, plain clamp for max-pool.
   always_comb begin
      acc_ext_s = {acc_in[ACC_WIDTH-1], acc_in};
      if (shift_q != 4'd0) begin
         round_s = RND_ONE << (shift_q - 4'd1);
      end else begin
         round_s = {(ACC_WIDTH+1){1'b0}};
      end
      sum_s    = acc_ext_s + round_s;
      scaled_s = sum_s >>> shift_q;
      if (op_q == 2'd0) begin
         y_s = sat8(scaled_s);
      end else begin
         y_s = sat8(acc_ext_s);
      end
   end

   // Sample classification and FIFO handshake decisions.
   always_comb begin
      start_s     = start && (state_q == S_IDLE);
      sample_s    = acc_valid && (state_q == S_RUN);
      last_s      = sample_s && (col_q == COL_W'(width_q - 8'd1))
                             && (row_q == ROW_W'(height_q - 8'd1));
      skip_done_s = acc_valid && (state_q == S_SKIP) && (skip_q == SKIP_W'(width_q));
      if (op_q == 2'd0) begin
         keep_s = sample_s;
      end else begin
         keep_s = sample_s && row_q[0] && col_q[0];
      end
      pop_s  = (cnt_q != {CNT_W{1'b0}}) && out_ready;
      full_s = (cnt_q == CNT_W'(FIFO_DEPTH));
      push_s = keep_s && (!full_s || pop_s);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!start) begin
               state_d = S_IDLE;
            end else if ((width == 8'd0) || (height == 8'd0)) begin
               state_d = S_DONE;
            end else if (operation == 2'd0) begin
               state_d = S_SKIP;
            end else if (operation == 2'd1) begin
               state_d = S_RUN;
            end else begin
               state_d = S_DONE;
            end
         end
         S_SKIP: begin
            if (skip_done_s) state_d = S_RUN;
            else             state_d = S_SKIP;
         end
         S_RUN: begin
            if (last_s) state_d = S_DRAIN;
            else        state_d = S_RUN;
         end
         S_DRAIN: begin
            if (cnt_q == {CNT_W{1'b0}}) state_d = S_DONE;
            else                        state_d = S_DRAIN;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs follow the state being entered so they can be registered.
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_d)
         S_SKIP, S_RUN, S_DRAIN: busy_d = 1'b1;
         S_DONE:                 done_d = 1'b1;
         default: begin
            busy_d = 1'b0;
            done_d = 1'b0;
         end
      endcase
   end

   // Registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   // Stage configuration, position counters, output index and FIFO storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         width_q  <= 8'd0;
         height_q <= 8'd0;
         op_q     <= 2'd0;
         shift_q  <= 4'd0;
         skip_q   <= {SKIP_W{1'b0}};
         col_q    <= {COL_W{1'b0}};
         row_q    <= {ROW_W{1'b0}};
         idx_q    <= 16'd0;
         wr_q     <= {PTR_W{1'b0}};
         rd_q     <= {PTR_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         ovf_q    <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pix_mem_q[i]  <= 8'd0;
            addr_mem_q[i] <= 16'd0;
         end
      end else if (start_s) begin
         width_q  <= width;
         height_q <= height;
         op_q     <= operation;
         shift_q  <= shift;
         skip_q   <= {SKIP_W{1'b0}};
         col_q    <= {COL_W{1'b0}};
         row_q    <= {ROW_W{1'b0}};
         idx_q    <= 16'd0;
         wr_q     <= {PTR_W{1'b0}};
         rd_q     <= {PTR_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         ovf_q    <= 1'b0;
      end else begin
         if (acc_valid && (state_q == S_SKIP)) begin
            skip_q <= skip_q + SKIP_W'(1);
         end
         if (sample_s) begin
            if (col_q == COL_W'(width_q - 8'd1)) begin
               col_q <= {COL_W{1'b0}};
               row_q <= row_q + ROW_W'(1);
            end else begin
               col_q <= col_q + COL_W'(1);
            end
         end
         // A dropped sample still consumes an output index.
         if (keep_s) begin
            idx_q <= idx_q + 16'd1;
            if (push_s) begin
               pix_mem_q[wr_q]  <= y_s;
               addr_mem_q[wr_q] <= idx_q;
               wr_q             <= wr_q + PTR_W'(1);
            end else begin
               ovf_q <= 1'b1;
            end
         end
         if (pop_s) begin
            rd_q <= rd_q + PTR_W'(1);
         end
         if (push_s && !pop_s) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else if (pop_s && !push_s) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end else begin
            cnt_q <= cnt_q;
         end
      end
   end

   assign pixel_out = pix_mem_q[rd_q];
   assign out_addr  = addr_mem_q[rd_q];
   assign out_valid = (cnt_q != {CNT_W{1'b0}});
   assign busy      = busy_q;
   assign done      = done_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_conv_output_stage.sv
// Randomised and directed bench for conv_output_stage, checked every cycle against
// a sample-count/queue reference model plus literal expectations on popped results.
module tb_conv_output_stage;

   localparam int ACC_W = 20;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst, start, acc_valid, out_ready;
   logic [7:0]       width, height;
   logic [1:0]       operation;
   logic [3:0]       shift;
   logic [ACC_W-1:0] acc_in;
   logic [7:0]       pixel_out;
   logic [15:0]      out_addr;
   logic             out_valid, busy, done, overflow;

   always #5 clk = ~clk;

   conv_output_stage #(
      .IMAGE_WIDTH(128), .IMAGE_HEIGHT(128), .ACC_WIDTH(ACC_W), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
      .operation(operation), .shift(shift), .acc_in(acc_in), .acc_valid(acc_valid),
      .pixel_out(pixel_out), .out_addr(out_addr), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done), .overflow(overflow)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(string name, int act, int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct { int pix; int addr; } ent_t;
   ent_t mq[$];      // expected FIFO contents
   ent_t log_q[$];   // entries actually handed to the writer
   int   exp_q[$];
   int   vals[$];

   int m_phase = 0;  // 0 idle, 1 taking samples, 2 draining, 3 done
   int mw, mh, mop, msh, mk, m_idx;
   bit m_ovf = 1'b0, m_busy = 1'b0, m_done = 1'b0;
   bit chk_en = 1'b0;
   int done_cnt = 0;

   function automatic int requant(int a, int op, int s);
      int y;
      if (op == 0) y = (a + ((s != 0) ? (1 << (s - 1)) : 0)) >>> s;
      else         y = a;
      if (y > 127) y = 127;
      else if (y < -128) y = -128;
      return y;
   endfunction

   task automatic model_step();
      bit pop, full, keep;
      int total;
      ent_t e;
      if (rst) begin
         mq.delete();
         m_phase = 0; m_busy = 0; m_done = 0; m_ovf = 0; m_idx = 0; mk = 0;
         return;
      end
      pop  = (mq.size() != 0) && out_ready;
      full = (mq.size() == DEPTH);
      keep = 0;
      m_done = 0;
      case (m_phase)
         0: if (start) begin
               mw = width; mh = height; mop = operation; msh = shift;
               m_ovf = 0; m_idx = 0; mk = 0;
               if (mw == 0 || mh == 0 || mop > 1) begin
                  m_phase = 3; m_done = 1; m_busy = 0;
               end else begin
                  m_phase = 1; m_busy = 1;
               end
            end
         1: if (acc_valid) begin
               if (mop == 0) begin
                  total = mw + 1 + mw * mh;
                  keep  = (mk >= mw + 1);
               end else begin
                  total = mw * mh;
                  keep  = ((mk / mw) % 2 == 1) && ((mk % mw) % 2 == 1);
               end
               if (mk == total - 1) m_phase = 2;
               mk++;
            end
         2: if (mq.size() == 0) begin
               m_phase = 3; m_done = 1; m_busy = 0;
            end
         default: m_phase = 0;
      endcase
      if (pop) void'(mq.pop_front());
      if (keep) begin
         if (!full || pop) begin
            e.pix  = requant($signed(acc_in), mop, msh);
            e.addr = m_idx;
            mq.push_back(e);
         end else begin
            m_ovf = 1;
         end
         m_idx++;
      end
   endtask

   always @(posedge clk) model_step();

   // Per-cycle comparison against the model, plus a log of every handshake.
   always @(negedge clk) begin
      ent_t e;
      if (chk_en) begin
         chk("out_valid", out_valid, mq.size() != 0);
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("overflow", overflow, m_ovf);
         if (mq.size() != 0) begin
            chk("pixel_out", $signed(pixel_out), mq[0].pix);
            chk("out_addr", out_addr, mq[0].addr);
         end
         if (done) done_cnt++;
         if (out_valid && out_ready) begin
            e.pix  = $signed(pixel_out);
            e.addr = out_addr;
            log_q.push_back(e);
         end
      end
   end

   task automatic expect_log(string name);
      chk({name, "_count"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         chk({name, "_pix"}, log_q[i].pix, exp_q[i]);
         chk({name, "_addr"}, log_q[i].addr, i);
      end
   endtask

   // vmode: 0 index, 1 random, 2 from vals; rmode: 0 ready, 1 random, 2 held low while feeding
   task automatic run_stage(int w, int h, int op, int sh, int vmode, int rmode, bit vrand, bit poke);
      int n_feed, sent, cyc, base, a;
      log_q.delete();
      base = done_cnt;
      n_feed = (w == 0 || h == 0) ? 0 : (op == 0) ? w + 1 + w * h : (op == 1) ? w * h : 0;
      @(posedge clk); #1;
      start = 1'b1; width = 8'(w); height = 8'(h); operation = 2'(op); shift = 4'(sh);
      acc_valid = 1'b0; out_ready = (rmode != 2);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("ovf_clear_on_start", overflow, 0);
      if (n_feed == 0) chk("done_next_cycle", done, 1);
      sent = 0; cyc = 0;
      while (sent < n_feed + 2 && cyc < 5000) begin
         @(posedge clk); #1;
         if (poke && cyc == 2 && n_feed >= 8) begin
            start = 1'b1; width = 8'd0;
         end else begin
            start = 1'b0; width = 8'(w);
         end
         acc_valid = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
         case (vmode)
            0:       a = sent;
            1:       a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2047)) - 1024 : int'($urandom);
            default: a = (sent < vals.size()) ? vals[sent] : 0;
         endcase
         acc_in = a[ACC_W-1:0];
         if (acc_valid) sent++;
         out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         cyc++;
      end
      @(posedge clk); #1;
      start = 1'b0; acc_valid = 1'b0;
      if (rmode == 2) begin
         repeat (4) @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      for (int i = 0; i < 400 && done_cnt == base; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt - base, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got time limit, expected bench completion");
      $fatal(1);
   end

   initial begin
      int w, h, op, base;
      rst = 1'b1; start = 1'b0; width = 8'd0; height = 8'd0; operation = 2'd0;
      shift = 4'd0; acc_in = '0; acc_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_pixel_out", pixel_out, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);

      run_stage(4, 4, 0, 0, 0, 0, 0, 0);
      exp_q.delete();
      for (int i = 5; i <= 20; i++) exp_q.push_back(i);
      expect_log("conv4x4");

      vals = '{0, 0, 6, -6, 1000, -1000, 7};
      run_stage(1, 5, 0, 2, 2, 0, 0, 0);
      exp_q = '{2, -1, 127, -128, 2};
      expect_log("round_shift2");

      vals = '{0, 0, -129};
      run_stage(1, 1, 0, 0, 2, 0, 0, 0);
      exp_q = '{-128};
      expect_log("sat_shift0");

      run_stage(4, 4, 1, 7, 0, 0, 0, 0);
      exp_q = '{5, 7, 13, 15};
      expect_log("maxpool4x4");

      run_stage(2, 2, 0, 0, 0, 2, 0, 0);
      exp_q = '{3, 4, 5, 6};
      expect_log("backpressure");
      chk("bp_overflow", overflow, 0);

      run_stage(3, 2, 0, 0, 0, 2, 0, 0);
      exp_q = '{4, 5, 6, 7};
      expect_log("overflow_drain");
      chk("ovf_sticky", overflow, 1);

      run_stage(0, 5, 0, 0, 0, 0, 0, 0);
      exp_q.delete();
      expect_log("width_zero");

      run_stage(3, 3, 2, 0, 0, 0, 0, 0);
      expect_log("reserved_op");

      // Abort mid-RUN with reset.
      base = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; width = 8'd4; height = 8'd4; operation = 2'd0; shift = 4'd0; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         acc_valid = 1'b1; acc_in = ACC_W'(i);
         @(posedge clk); #1;
      end
      acc_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_done", done, 0);
      repeat (3) @(negedge clk);
      chk("abort_no_done", done_cnt - base, 0);
      run_stage(2, 3, 0, 1, 1, 1, 1, 0);

      for (int n = 0; n < 14; n++) begin
         w  = $urandom_range(1, 6);
         h  = $urandom_range(1, 6);
         op = ($urandom_range(0, 7) == 0) ? 2 : $urandom_range(0, 1);
         run_stage(w, h, op, $urandom_range(0, 15), 1, 1, 1, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
